// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
package mips_mem_pkg;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int MAX_WAIT_DEF = 15;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts WAIT cycles without a memory acknowledge and flags the cycle in
// which the MAX_WAIT-th unacknowledged cycle occurs.
module mem_wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != CNT_W'(MAX_WAIT))) begin
         count <= count + CNT_W'(1);
      end
   end

   // count holds the number of earlier unacknowledged cycles, so this cycle
   // is the MAX_WAIT-th one when count has reached MAX_WAIT-1.
   assign expired = enable && (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access sequencer with ack timeout.
// Optional build macro MEM_ALIGN_CHECK_EN: reject word-misaligned accesses.
//
//   state  | meaning
//   IDLE   | no access outstanding; a new load/store is launched from here
//   WAIT   | request on the bus, waiting for dmem_ack or timeout
//   DONE   | access finished; pipeline released for one cycle
module mem_access_unit
   import mips_mem_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              MemReadM,
   input  logic              MemWriteM,
   input  logic [ADDR_W-1:0] ALUOutM,
   input  logic [DATA_W-1:0] WriteDataM,
   output logic [DATA_W-1:0] RD,
   output logic              StallM,
   output logic              BusErrM,
   output logic              MisalignM,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack
);

   mem_state_e state, state_next;

   logic access;
   logic misaligned;
   logic start;
   logic ack_hit;
   logic timeout;
   logic misalign_hit;
   logic stall;
   logic wait_no_ack;
   logic timer_expired;
   logic misalign_q;

   assign access = MemReadM | MemWriteM;

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = |ALUOutM[1:0];
   assign MisalignM  = misalign_q;
`else
   logic unused_align;
   assign misaligned   = 1'b0;
   assign MisalignM    = 1'b0;
   assign unused_align = ^{ALUOutM[1:0], misalign_q};
`endif

   assign wait_no_ack = (state == S_WAIT) && !dmem_ack;

   mem_wait_timer #(
      .MAX_WAIT(MAX_WAIT)
   ) u_wait_timer (
      .clock  (clock),
      .reset  (reset),
      .clear  (start),
      .enable (wait_no_ack),
      .expired(timer_expired)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      stall        = 1'b0;
      start        = 1'b0;
      ack_hit      = 1'b0;
      timeout      = 1'b0;
      misalign_hit = 1'b0;
      case (state)
         S_IDLE: begin
            if (access) begin
               if (misaligned) begin
                  misalign_hit = 1'b1;
               end else begin
                  start      = 1'b1;
                  stall      = 1'b1;
                  state_next = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            stall = 1'b1;
            // An ack in the last allowed cycle wins over the timeout.
            if (dmem_ack) begin
               ack_hit    = 1'b1;
               state_next = S_DONE;
            end else if (timer_expired) begin
               timeout    = 1'b1;
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign StallM = stall && !reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         RD         <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         BusErrM    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         BusErrM    <= timeout;
         misalign_q <= misalign_hit;
         if (start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWriteM;
            dmem_addr  <= {ALUOutM[ADDR_W-1:2], 2'b00};
            dmem_wdata <= WriteDataM;
         end
         if (ack_hit || timeout) begin
            dmem_req <= 1'b0;
         end
         // dmem_we doubles as the "this was a store" flag, so read+write
         // requests leave RD untouched.
         if (ack_hit && !dmem_we) begin
            RD <= dmem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit plus reset and alignment sequences.
module tb_mem_access_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        MemReadM, MemWriteM;
   logic [31:0] ALUOutM, WriteDataM;
   logic [31:0] RD;
   logic        StallM, BusErrM, MisalignM;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_access_unit #(.MAX_WAIT(15)) dut (
      .clock     (clock),
      .reset     (reset),
      .MemReadM  (MemReadM),
      .MemWriteM (MemWriteM),
      .ALUOutM   (ALUOutM),
      .WriteDataM(WriteDataM),
      .RD        (RD),
      .StallM    (StallM),
      .BusErrM   (BusErrM),
      .MisalignM (MisalignM),
      .dmem_req  (dmem_req),
      .dmem_we   (dmem_we),
      .dmem_addr (dmem_addr),
      .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata),
      .dmem_ack  (dmem_ack)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          delay;      // WAIT cycles before ack; -1 = never ack
      logic [31:0] rdata;
      logic [31:0] exp_rd;
      logic        exp_we;
      logic [31:0] exp_addr;
      int          exp_stall;
      logic        exp_berr;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int stalls;
      int nwait;
      stalls = 0;
      nwait  = (v.delay < 0) ? 15 : v.delay + 1;
      step();
      MemReadM   = v.rd;
      MemWriteM  = v.wr;
      ALUOutM    = v.addr;
      WriteDataM = v.wdata;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      sample();
      stalls += int'(StallM);
      chk($sformatf("v%0d_idle_req", idx), dmem_req, 1'b0);
      for (int i = 0; i < nwait; i++) begin
         step();
         dmem_ack   = (i == v.delay);
         dmem_rdata = (i == v.delay) ? v.rdata : (32'hFFFF0000 | i);
         sample();
         stalls += int'(StallM);
         chk($sformatf("v%0d_w%0d_req", idx, i), dmem_req, 1'b1);
         chk($sformatf("v%0d_w%0d_addr", idx, i), dmem_addr, v.exp_addr);
         chk($sformatf("v%0d_w%0d_wdata", idx, i), dmem_wdata, v.wdata);
         chk($sformatf("v%0d_w%0d_we", idx, i), dmem_we, v.exp_we);
         chk($sformatf("v%0d_w%0d_berr", idx, i), BusErrM, 1'b0);
      end
      // DONE: instruction still present, late ack with junk data must be ignored
      step();
      dmem_ack   = 1'b1;
      dmem_rdata = ~v.exp_rd;
      sample();
      chk($sformatf("v%0d_done_stall", idx), StallM, 1'b0);
      chk($sformatf("v%0d_done_req", idx), dmem_req, 1'b0);
      chk($sformatf("v%0d_done_rd", idx), RD, v.exp_rd);
      chk($sformatf("v%0d_done_berr", idx), BusErrM, v.exp_berr);
      chk($sformatf("v%0d_stall_cycles", idx), stalls, v.exp_stall);
      step();
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
      dmem_ack  = 1'b0;
      sample();
      chk($sformatf("v%0d_post_req", idx), dmem_req, 1'b0);
      chk($sformatf("v%0d_post_rd", idx), RD, v.exp_rd);
      chk($sformatf("v%0d_post_berr", idx), BusErrM, 1'b0);
      chk($sformatf("v%0d_post_stall", idx), StallM, 1'b0);
   endtask

   initial begin
      //          rd    wr    addr          wdata         dly rdata         exp_rd        we    exp_addr      stall berr
      vecs[0] = '{1'b1, 1'b0, 32'h00000100, 32'h00000000,  0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h00000100,  2, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 32'h00000204, 32'h12345678,  3, 32'hAAAA5555, 32'hDEADBEEF, 1'b1, 32'h00000204,  5, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 32'h00000400, 32'h00000000, -1, 32'h00000000, 32'hDEADBEEF, 1'b0, 32'h00000400, 16, 1'b1};
      vecs[3] = '{1'b1, 1'b1, 32'h00000300, 32'hCAFEF00D,  1, 32'h11111111, 32'hDEADBEEF, 1'b1, 32'h00000300,  3, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 32'h00007FFC, 32'h00000000, 14, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 32'h00007FFC, 16, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h00000000,  0, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0, 32'hFFFFFFFC,  2, 1'b0};

      reset      = 1'b1;
      MemReadM   = 1'b1;
      MemWriteM  = 1'b0;
      ALUOutM    = 32'h00000100;
      WriteDataM = 32'h0;
      dmem_rdata = 32'h0;
      dmem_ack   = 1'b0;
      step();
      step();
      sample();
      chk("rst_stall", StallM, 1'b0);
      chk("rst_rd", RD, 32'h0);
      chk("rst_req", dmem_req, 1'b0);
      chk("rst_we", dmem_we, 1'b0);
      chk("rst_addr", dmem_addr, 32'h0);
      chk("rst_wdata", dmem_wdata, 32'h0);
      chk("rst_berr", BusErrM, 1'b0);
      chk("rst_mis", MisalignM, 1'b0);
      step();
      reset    = 1'b0;
      MemReadM = 1'b0;

      for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

      // reset in the 2nd WAIT cycle, then a late ack
      step();
      MemReadM = 1'b1;
      ALUOutM  = 32'h00000500;
      WriteDataM = 32'h77777777;
      step();
      sample();
      chk("ra_w1_req", dmem_req, 1'b1);
      step();
      reset = 1'b1;
      sample();
      chk("ra_rst_stall", StallM, 1'b0);
      step();
      reset      = 1'b0;
      MemReadM   = 1'b0;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h99999999;
      sample();
      chk("ra_req", dmem_req, 1'b0);
      chk("ra_addr", dmem_addr, 32'h0);
      chk("ra_wdata", dmem_wdata, 32'h0);
      chk("ra_we", dmem_we, 1'b0);
      chk("ra_rd", RD, 32'h0);
      chk("ra_stall", StallM, 1'b0);
      chk("ra_berr", BusErrM, 1'b0);
      step();
      dmem_ack = 1'b0;
      sample();
      chk("ra_late_rd", RD, 32'h0);
      chk("ra_late_req", dmem_req, 1'b0);

      // misaligned load at 0x103
      step();
      MemReadM = 1'b1;
      ALUOutM  = 32'h00000103;
      dmem_rdata = 32'h13572468;
`ifdef MEM_ALIGN_CHECK_EN
      sample();
      chk("mis_idle_stall", StallM, 1'b0);
      step();
      MemReadM = 1'b0;
      sample();
      chk("mis_pulse", MisalignM, 1'b1);
      chk("mis_req", dmem_req, 1'b0);
      chk("mis_rd", RD, 32'h0);
      step();
      sample();
      chk("mis_pulse_end", MisalignM, 1'b0);
      chk("mis_req_end", dmem_req, 1'b0);
`else
      sample();
      chk("trunc_idle_stall", StallM, 1'b1);
      step();
      dmem_ack = 1'b1;
      sample();
      chk("trunc_addr", dmem_addr, 32'h00000100);
      chk("trunc_req", dmem_req, 1'b1);
      chk("trunc_mis", MisalignM, 1'b0);
      step();
      MemReadM = 1'b0;
      dmem_ack = 1'b0;
      sample();
      chk("trunc_rd", RD, 32'h13572468);
      chk("trunc_mis_done", MisalignM, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning the most cycles to wait for dmem_ack before aborting.
REQ-002 SHALL have port clock  in  1  single clock; all state updates on posedge; one clock domain only.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port MemReadM  in  1  load in MEM stage.
REQ-005 SHALL have port MemWriteM  in  1  store in MEM stage.
REQ-006 SHALL have port ALUOutM  in  32  effective byte address.
REQ-007 SHALL have port WriteDataM  in  32  store data.
REQ-008 SHALL have port RD  out  32  load data; feeds the MEM/WB register.
REQ-009 SHALL have port StallM  out  1  freeze the PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-010 SHALL have port BusErrM  out  1  one-cycle pulse when an access times out.
REQ-011 SHALL have port MisalignM  out  1  one-cycle pulse on a misaligned access (see REQ-029).
REQ-012 SHALL have ports dmem_req/dmem_we  out  1  registered request and write-enable.
REQ-013 SHALL have ports dmem_addr/dmem_wdata  out  32  registered address and write data.
REQ-014 SHALL have ports dmem_rdata  in  32  and dmem_ack  in  1  memory response.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-016 IDLE with (MemReadM|MemWriteM) SHALL register dmem_req=1, dmem_addr={ALUOutM[31:2],2'b00}, dmem_wdata=WriteDataM and dmem_we=MemWriteM, then go to WAIT.
REQ-017 When MemReadM and MemWriteM are both high, the write SHALL take priority and RD SHALL stay unchanged.
REQ-018 StallM SHALL be combinational: 1 when (IDLE & access) or WAIT, otherwise 0.
REQ-019 In WAIT with dmem_ack=1, the unit SHALL drop dmem_req, latch RD<=dmem_rdata (reads only) and go to DONE.
REQ-020 In DONE, StallM SHALL be 0, MemReadM/MemWriteM SHALL be ignored (same instruction), and the next state SHALL be IDLE.
REQ-021 Minimum access latency SHALL be 3 cycles (IDLE, WAIT, DONE) with dmem_ack high in the first WAIT cycle.
REQ-022 A wait counter SHALL clear on entering WAIT and increment each WAIT cycle without ack.
REQ-023 When the wait count reaches MAX_WAIT without ack, the unit SHALL drop dmem_req, pulse BusErrM, leave RD unchanged and go to DONE.
REQ-024 dmem_ack SHALL be ignored outside WAIT.
REQ-025 dmem_addr/dmem_wdata/dmem_we SHALL be held stable while dmem_req=1.

Reset
REQ-026 reset SHALL force state IDLE, RD=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wait counter=0, BusErrM=0 and MisalignM=0.
REQ-027 reset asserted mid-access SHALL abort at that edge, and a late dmem_ack after reset SHALL be ignored.
REQ-028 StallM SHALL be 0 during reset.

Configuration
REQ-029 With MEM_ALIGN_CHECK_EN defined, an IDLE access with ALUOutM[1:0]!=0 SHALL issue no request, SHALL NOT assert StallM, SHALL pulse MisalignM the next cycle and SHALL leave RD unchanged.
REQ-030 Without MEM_ALIGN_CHECK_EN, MisalignM SHALL be tied 0 and the address SHALL be word-truncated per REQ-016.

Structure
REQ-031 Package mips_mem_pkg SHALL hold the FSM state enum, the MAX_WAIT default and the 32-bit address/data width constants.
REQ-032 The wait counter and timeout compare SHALL be one sub-module, mem_wait_timer; the rest stays in mem_access_unit.

Verification
REQ-033 Load addr 0x100, ack in 1st WAIT cycle with rdata 0xDEADBEEF -> StallM high for 2 cycles, RD=0xDEADBEEF in DONE.
REQ-034 Store addr 0x204, data 0x12345678, ack after 4 cycles -> dmem_we=1, addr/data stable 4 cycles, RD unchanged.
REQ-035 Load with no ack, MAX_WAIT=15 -> BusErrM pulses after 15 WAIT cycles, dmem_req drops, StallM releases.
REQ-036 reset in 2nd WAIT cycle, then ack next cycle -> IDLE, all outputs 0, ack ignored.
REQ-037 MEM_ALIGN_CHECK_EN defined, load addr 0x103 -> MisalignM pulse, no dmem_req, StallM 0; macro undefined -> dmem_addr=0x100.
REQ-038 MemReadM and MemWriteM both high at 0x300 -> write issued, RD unchanged.
